hazard_ctrl_param: RTL and testbench

//  Parametrised ID-stage hazard/stall controller for the 5-stage MIPS pipeline; successor to the fixed two-stage cache-miss hazard unit.

---
 rtl/hazard_ctrl_param.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_hazard_ctrl_param.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_param.sv
// =============================================================================
// hazard_ctrl_param
// -----------------------------------------------------------------------------
// ID-stage hazard and stall controller for the 5-stage MIPS pipeline.
//
// It generalises the fixed two-stage cache-miss hazard unit in three ways:
//   * the JR dependency check covers NUM_WB_STAGES downstream stages that can
//     still hold a pending register write,
//   * a load-use hazard inserts LOAD_USE_CYCLES bubbles (1..15), tracked by a
//     4-bit down-counter,
//   * a D-cache miss freezes the whole controller: state and counter are held
//     and pipeStall tells every pipeline register to hold.
// It also sequences I-cache misses, exception redirects, jumps and
// taken-branch / delay-slot flushes.
//
// Parameters
//   REG_AW          register-address width
//   NUM_WB_STAGES   downstream stages with a possible pending write (>=1)
//   LOAD_USE_CYCLES bubbles inserted per load-use hazard (1..15)
//   CNT_W           width of the performance counters
//
// Ports
//   Clk          in   clock, all state updates on the rising edge
//   Rst          in   asynchronous reset, active-low; forces all outputs to 0
//   ICacheMiss   in   fetch miss, hold PC
//   DCacheMiss   in   data miss, freeze controller and pipeline
//   exception    in   trap request, redirect to exception vector
//   Jump         in   J/JAL decoded in ID
//   Jr           in   JR decoded in ID
//   Branch[1:0]  in   bit 0 = conditional branch in ID (bit 1 not used here)
//   taken        in   branch resolved taken
//   needFlush    in   delay-slot flush request after a branch
//   memReadEX    in   instruction in EX is a load
//   UseShamt     in   ID instruction does not read Rt
//   UseImmed     in   ID instruction does not read the Rs/Rt pair
//   currRs       in   ID source register Rs
//   currRt       in   ID source register Rt
//   prevRt       in   destination register of the load in EX
//   rwRegW_vec   in   per stage k {rw_k, regW_k}, stage 0 (nearest) in MSBs
//   PC_Write     out  PC register write enable
//   IF_Write     out  IF/ID register write enable
//   IF_Flush     out  flush IF/ID
//   bubble       out  turn the ID instruction into a bubble
//   addrSel      out  00 PC+4, 01 jump/jr target, 10 branch target,
//                     11 exception vector
//   pipeStall    out  freeze all pipeline registers
//   stallCycles  out  (HAZ_PERF_EN only) saturating count of stalled cycles
//   flushCount   out  (HAZ_PERF_EN only) saturating count of IF flushes
//
// Build option
//   HAZ_PERF_EN  when defined, adds the stallCycles / flushCount counters.
// =============================================================================
module hazard_ctrl_param #(
    parameter int REG_AW          = 5,
    parameter int NUM_WB_STAGES   = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic                                   ICacheMiss,
    input  logic                                   DCacheMiss,
    input  logic                                   exception,
    input  logic                                   Jump,
    input  logic                                   Jr,
    input  logic [1:0]                             Branch,
    input  logic                                   taken,
    input  logic                                   needFlush,
    input  logic                                   memReadEX,
    input  logic                                   UseShamt,
    input  logic                                   UseImmed,
    input  logic [REG_AW-1:0]                      currRs,
    input  logic [REG_AW-1:0]                      currRt,
    input  logic [REG_AW-1:0]                      prevRt,
    input  logic [NUM_WB_STAGES*(REG_AW+1)-1:0]    rwRegW_vec,
    output logic                                   PC_Write,
    output logic                                   IF_Write,
    output logic                                   IF_Flush,
    output logic                                   bubble,
    output logic [1:0]                             addrSel,
    output logic                                   pipeStall
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]                       stallCycles,
    output logic [CNT_W-1:0]                       flushCount
`endif
);

    typedef enum logic [2:0] {
        S_RUN,
        S_LDSTALL,
        S_JUMP,
        S_JRWAIT,
        S_BR0,
        S_BR1
    } state_t;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_JUMP = 2'b01;
    localparam logic [1:0] SEL_BR   = 2'b10;
    localparam logic [1:0] SEL_EXC  = 2'b11;

    // Counter value loaded when a load-use hazard is first detected; the
    // detecting cycle already emits the first bubble.
    localparam logic [3:0] LU_INIT = 4'(LOAD_USE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Only bit 0 of Branch carries meaning for this controller.
    logic unused_branch_hi;
    assign unused_branch_hi = Branch[1];

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic                     ld_haz;
    logic [NUM_WB_STAGES-1:0] jr_dep;
    logic                     any_jr_dep;

    assign ld_haz = memReadEX && (prevRt != '0) && !UseImmed && !UseShamt &&
                    ((currRs == prevRt) || (currRt == prevRt));

    // One comparator per downstream stage. Stage 0 sits in the MSBs of the
    // vector; each field is {rw, regW}. Register 0 never creates a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB_STAGES; gi++) begin : g_jr_dep
            localparam int HI = (NUM_WB_STAGES - gi) * (REG_AW + 1) - 1;
            logic [REG_AW-1:0] rw;
            logic              reg_w;
            assign rw          = rwRegW_vec[HI -: REG_AW];
            assign reg_w       = rwRegW_vec[HI - REG_AW];
            assign jr_dep[gi]  = reg_w && (rw != '0) && (rw == currRs);
        end
    endgenerate

    assign any_jr_dep = |jr_dep;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= S_RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and raw outputs
    // -------------------------------------------------------------------------
    logic       pc_write_c, if_write_c, if_flush_c, bubble_c, pipe_stall_c;
    logic [1:0] addr_sel_c;

    always_comb begin
        // Normal flow unless a case below overrides it.
        pc_write_c   = 1'b1;
        if_write_c   = 1'b1;
        if_flush_c   = 1'b0;
        bubble_c     = 1'b0;
        addr_sel_c   = SEL_PC4;
        pipe_stall_c = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;

        if (DCacheMiss) begin
            // Global freeze: everything holds, state and counter included.
            pc_write_c   = 1'b0;
            if_write_c   = 1'b0;
            pipe_stall_c = 1'b1;
        end else if (exception) begin
            // Redirect to the handler from any state, abandoning any stall.
            if_write_c = 1'b0;
            if_flush_c = 1'b1;
            bubble_c   = 1'b1;
            addr_sel_c = SEL_EXC;
            state_next = S_RUN;
            cnt_next   = 4'd0;
        end else begin
            unique case (state_reg)
                S_RUN: begin
                    if (ICacheMiss) begin
                        pc_write_c = 1'b0;
                    end else if (Jump) begin
                        if_write_c = 1'b0;
                        addr_sel_c = SEL_JUMP;
                        state_next = S_JUMP;
                    end else if (Jr && any_jr_dep) begin
                        // Target register still in flight: hold and wait.
                        pc_write_c = 1'b0;
                        if_write_c = 1'b0;
                        bubble_c   = 1'b1;
                        addr_sel_c = SEL_JUMP;
                        state_next = S_JRWAIT;
                    end else if (Jr) begin
                        if_write_c = 1'b0;
                        bubble_c   = 1'b1;
                        addr_sel_c = SEL_JUMP;
                        state_next = S_JUMP;
                    end else if (ld_haz) begin
                        pc_write_c = 1'b0;
                        if_write_c = 1'b0;
                        bubble_c   = 1'b1;
                        cnt_next   = LU_INIT;
                        state_next = (LOAD_USE_CYCLES > 1) ? S_LDSTALL : S_RUN;
                    end else if (Branch[0] && taken) begin
                        if_write_c = 1'b0;
                        if_flush_c = 1'b1;
                        addr_sel_c = SEL_BR;
                        state_next = S_BR0;
                    end else if (Branch[0]) begin
                        state_next = S_BR0;
                    end
                end

                S_LDSTALL: begin
                    pc_write_c = 1'b0;
                    if_write_c = 1'b0;
                    bubble_c   = 1'b1;
                    // The bubble emitted with counter==1 is the last one.
                    if (cnt_reg <= 4'd1) begin
                        cnt_next   = 4'd0;
                        state_next = S_RUN;
                    end else begin
                        cnt_next   = cnt_reg - 4'd1;
                    end
                end

                S_JRWAIT: begin
                    if_write_c = 1'b0;
                    bubble_c   = 1'b1;
                    addr_sel_c = SEL_JUMP;
                    if (any_jr_dep) begin
                        pc_write_c = 1'b0;
                    end else begin
                        state_next = S_JUMP;
                    end
                end

                S_JUMP: begin
                    state_next = S_RUN;
                end

                S_BR0: begin
                    if (needFlush) begin
                        if_write_c = 1'b0;
                        if_flush_c = 1'b1;
                        bubble_c   = 1'b1;
                        addr_sel_c = SEL_EXC;
                        state_next = S_BR1;
                    end else if (Jump) begin
                        if_write_c = 1'b0;
                        addr_sel_c = SEL_JUMP;
                        state_next = S_JUMP;
                    end else begin
                        state_next = S_RUN;
                    end
                end

                S_BR1: begin
                    if (Jump) begin
                        if_write_c = 1'b0;
                        addr_sel_c = SEL_JUMP;
                        state_next = S_JUMP;
                    end else begin
                        state_next = S_RUN;
                    end
                end

                default: begin
                    state_next = S_RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    // While reset is held every control output is driven low, independent of
    // the (already reset) state.
    assign PC_Write  = Rst & pc_write_c;
    assign IF_Write  = Rst & if_write_c;
    assign IF_Flush  = Rst & if_flush_c;
    assign bubble    = Rst & bubble_c;
    assign pipeStall = Rst & pipe_stall_c;
    assign addrSel   = Rst ? addr_sel_c : SEL_PC4;

`ifdef HAZ_PERF_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if ((!PC_Write || pipeStall) && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (IF_Flush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stallCycles = stall_cnt_reg;
    assign flushCount  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// =============================================================================
// tb_hazard_ctrl_param
// Directed testbench for hazard_ctrl_param with NUM_WB_STAGES=3 and
// LOAD_USE_CYCLES=3. Each step drives one input pattern, checks the packed
// output vector {PC_Write, IF_Write, IF_Flush, bubble, addrSel, pipeStall}
// against a hand-written expectation, then advances one clock.
// =============================================================================
module tb_hazard_ctrl_param;

    localparam int REG_AW = 5;
    localparam int NWB    = 3;
    localparam int LUC    = 3;
    localparam int CNT_W  = 3;

    // Input pattern fields: {icm, dcm, exc, jmp, jr, br[1:0], tkn, nf, mr}
    localparam logic [9:0] I_NONE = 10'b0000000000;
    localparam logic [9:0] I_ICM  = 10'b1000000000;
    localparam logic [9:0] I_DCM  = 10'b0100000000;
    localparam logic [9:0] I_EXC  = 10'b0010000000;
    localparam logic [9:0] I_JMP  = 10'b0001000000;
    localparam logic [9:0] I_JR   = 10'b0000100000;
    localparam logic [9:0] I_BR   = 10'b0000001000;
    localparam logic [9:0] I_TK   = 10'b0000000100;
    localparam logic [9:0] I_NF   = 10'b0000000010;
    localparam logic [9:0] I_MR   = 10'b0000000001;

    // Expected outputs {PC_Write, IF_Write, IF_Flush, bubble, addrSel, pipeStall}
    localparam logic [6:0] E_NORM = 7'b1100000;
    localparam logic [6:0] E_ICM  = 7'b0100000;
    localparam logic [6:0] E_JMP  = 7'b1000010;
    localparam logic [6:0] E_JRS  = 7'b0001010;
    localparam logic [6:0] E_JRJ  = 7'b1001010;
    localparam logic [6:0] E_LDS  = 7'b0001000;
    localparam logic [6:0] E_BRT  = 7'b1010100;
    localparam logic [6:0] E_BRF  = 7'b1011110;
    localparam logic [6:0] E_EXC  = 7'b1011110;
    localparam logic [6:0] E_FRZ  = 7'b0000001;
    localparam logic [6:0] E_ZERO = 7'b0000000;

    logic                      Clk = 1'b0;
    logic                      Rst = 1'b0;
    logic                      ICacheMiss, DCacheMiss, exception, Jump, Jr;
    logic [1:0]                Branch;
    logic                      taken, needFlush, memReadEX, UseShamt, UseImmed;
    logic [REG_AW-1:0]         currRs, currRt, prevRt;
    logic [NWB*(REG_AW+1)-1:0] rwRegW_vec;
    logic                      PC_Write, IF_Write, IF_Flush, bubble, pipeStall;
    logic [1:0]                addrSel;
`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0]          stallCycles, flushCount;
`endif

    int checks = 0;
    int errors = 0;

    wire [6:0] outs = {PC_Write, IF_Write, IF_Flush, bubble, addrSel, pipeStall};

    always #5 Clk = ~Clk;

    hazard_ctrl_param #(
        .REG_AW(REG_AW), .NUM_WB_STAGES(NWB), .LOAD_USE_CYCLES(LUC), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss), .exception(exception),
        .Jump(Jump), .Jr(Jr), .Branch(Branch), .taken(taken), .needFlush(needFlush),
        .memReadEX(memReadEX), .UseShamt(UseShamt), .UseImmed(UseImmed),
        .currRs(currRs), .currRt(currRt), .prevRt(prevRt), .rwRegW_vec(rwRegW_vec),
        .PC_Write(PC_Write), .IF_Write(IF_Write), .IF_Flush(IF_Flush),
        .bubble(bubble), .addrSel(addrSel), .pipeStall(pipeStall)
`ifdef HAZ_PERF_EN
        , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
    );

    task automatic apply(input logic [9:0] v);
        {ICacheMiss, DCacheMiss, exception, Jump, Jr, Branch, taken, needFlush, memReadEX} = v;
    endtask

    task automatic set_regs(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] prt,
                            input logic imm, input logic shamt, input logic [17:0] vec);
        currRs = rs; currRt = rt; prevRt = prt; UseImmed = imm; UseShamt = shamt;
        rwRegW_vec = vec;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] pats [3] = '{I_NONE, I_JMP, I_DCM};
        set_regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 3; i++) begin
            apply(pats[i]);
            #2;
            checks++;
            if (outs !== E_ZERO) begin
                errors++;
                $display("FAIL reset step %0d: got %b expected %b", i, outs, E_ZERO);
            end
        end
        apply(I_NONE);
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        checks++;
        if (outs !== E_NORM) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", outs, E_NORM);
        end
    endtask

    task automatic test_load_use();
        logic [16:0] seq_a [5] = '{{I_MR, E_LDS}, {I_NONE, E_LDS}, {I_NONE, E_LDS},
                                   {I_NONE, E_NORM}, {I_NONE, E_NORM}};
        // lw $5 / ID reads $5 via Rs
        set_regs(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 5; i++) begin
            apply(seq_a[i][16:7]);
            #1;
            checks++;
            if (outs !== seq_a[i][6:0]) begin
                errors++;
                $display("FAIL load_use_rs step %0d: got %b expected %b", i, outs, seq_a[i][6:0]);
            end
            tick();
        end
        // Same reads via Rt
        set_regs(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 5; i++) begin
            apply(seq_a[i][16:7]);
            #1;
            checks++;
            if (outs !== seq_a[i][6:0]) begin
                errors++;
                $display("FAIL load_use_rt step %0d: got %b expected %b", i, outs, seq_a[i][6:0]);
            end
            tick();
        end
        // prevRt=0, UseImmed, UseShamt each suppress the hazard
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 18'd0);
            if (i == 1) set_regs(5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 18'd0);
            if (i == 2) set_regs(5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 18'd0);
            apply(I_MR);
            #1;
            checks++;
            if (outs !== E_NORM) begin
                errors++;
                $display("FAIL load_use_none case %0d: got %b expected %b", i, outs, E_NORM);
            end
            tick();
        end
        apply(I_NONE);
    endtask

    task automatic test_jr_wait();
        // All three stages hold rw=7 with regW=0; regW of one stage is raised.
        logic [17:0] base = 18'b001110_001110_001110;
        logic        dep_on [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [16:0] seq [5] = '{{I_JR, E_JRS}, {I_NONE, E_JRS}, {I_NONE, E_JRJ},
                                 {I_NONE, E_NORM}, {I_NONE, E_NORM}};
        logic [16:0] seq_b [4] = '{{I_JR, E_JRJ}, {I_NONE, E_NORM},
                                   {I_JMP | I_JR, E_JMP}, {I_NONE, E_NORM}};
        for (int k = 0; k < NWB; k++) begin
            for (int i = 0; i < 5; i++) begin
                set_regs(5'd7, 5'd0, 5'd0, 1'b0, 1'b0,
                         dep_on[i] ? (base | (18'd1 << ((NWB - 1 - k) * 6))) : base);
                apply(seq[i][16:7]);
                #1;
                checks++;
                if (outs !== seq[i][6:0]) begin
                    errors++;
                    $display("FAIL jr_wait stage %0d step %0d: got %b expected %b",
                             k, i, outs, seq[i][6:0]);
                end
                tick();
            end
        end
        // Register 0 in flight never blocks JR; Jump beats Jr
        set_regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 18'b000001_000001_000001);
        for (int i = 0; i < 4; i++) begin
            apply(seq_b[i][16:7]);
            #1;
            checks++;
            if (outs !== seq_b[i][6:0]) begin
                errors++;
                $display("FAIL jr_nodep step %0d: got %b expected %b", i, outs, seq_b[i][6:0]);
            end
            tick();
        end
    endtask

    task automatic test_freeze();
        logic [16:0] seq [13] = '{{I_MR, E_LDS}, {I_DCM, E_FRZ}, {I_DCM, E_FRZ},
                                  {I_DCM, E_FRZ}, {I_DCM, E_FRZ}, {I_NONE, E_LDS},
                                  {I_NONE, E_LDS}, {I_NONE, E_NORM},
                                  {I_DCM | I_EXC, E_FRZ}, {I_NONE, E_NORM},
                                  {I_DCM | I_JMP, E_FRZ}, {I_JMP, E_JMP}, {I_NONE, E_NORM}};
        set_regs(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 13; i++) begin
            apply(seq[i][16:7]);
            #1;
            checks++;
            if (outs !== seq[i][6:0]) begin
                errors++;
                $display("FAIL freeze step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [16:0] seq [12] = '{{I_BR | I_TK, E_BRT}, {I_NF, E_BRF}, {I_NONE, E_NORM},
                                  {I_NONE, E_NORM},
                                  {I_BR, E_NORM}, {I_JMP, E_JMP}, {I_NONE, E_NORM},
                                  {I_BR | I_TK, E_BRT}, {I_NF, E_BRF}, {I_JMP, E_JMP},
                                  {I_NONE, E_NORM}, {I_NONE, E_NORM}};
        set_regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 12; i++) begin
            apply(seq[i][16:7]);
            #1;
            checks++;
            if (outs !== seq[i][6:0]) begin
                errors++;
                $display("FAIL branch step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
            tick();
        end
    endtask

    task automatic test_exception();
        logic [16:0] seq [8] = '{{I_ICM | I_EXC, E_EXC}, {I_NONE, E_NORM},
                                 {I_ICM, E_ICM}, {I_NONE, E_NORM},
                                 {I_MR, E_LDS}, {I_EXC, E_EXC}, {I_NONE, E_NORM},
                                 {I_NONE, E_NORM}};
        set_regs(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 18'd0);
        for (int i = 0; i < 8; i++) begin
            apply(seq[i][16:7]);
            #1;
            checks++;
            if (outs !== seq[i][6:0]) begin
                errors++;
                $display("FAIL exception step %0d: got %b expected %b", i, outs, seq[i][6:0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_jrwait();
        // Stage 0 holds a pending write to $7 throughout
        set_regs(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 18'b001111_000000_000000);
        apply(I_JR);
        tick();
        apply(I_NONE);
        #1;
        checks++;
        if (outs !== E_JRS) begin
            errors++;
            $display("FAIL rst_mid_jrwait pre: got %b expected %b", outs, E_JRS);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (outs !== E_ZERO) begin
            errors++;
            $display("FAIL rst_mid_jrwait async: got %b expected %b", outs, E_ZERO);
        end
        tick();
        Rst = 1'b1;
        #1;
        // Back in RUN: dependency still present but no JR, so normal flow
        checks++;
        if (outs !== E_NORM) begin
            errors++;
            $display("FAIL rst_mid_jrwait post: got %b expected %b", outs, E_NORM);
        end
        tick();
    endtask

`ifdef HAZ_PERF_EN
    task automatic test_perf();
        set_regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 18'd0);
        apply(I_NONE);
        Rst = 1'b0;
        #1;
        checks++;
        if (stallCycles !== 3'd0 || flushCount !== 3'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", stallCycles, flushCount);
        end
        Rst = 1'b1;
        tick();
        apply(I_ICM);
        repeat (5) tick();
        apply(I_EXC);
        repeat (2) tick();
        apply(I_NONE);
        #1;
        checks++;
        if (stallCycles !== 3'd5 || flushCount !== 3'd2) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d expected 5/2", stallCycles, flushCount);
        end
        apply(I_ICM);
        repeat (4) tick();
        apply(I_EXC);
        repeat (6) tick();
        apply(I_NONE);
        #1;
        checks++;
        if (stallCycles !== 3'd7 || flushCount !== 3'd7) begin
            errors++;
            $display("FAIL perf_saturate: got %0d/%0d expected 7/7", stallCycles, flushCount);
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        apply(I_NONE);
        test_reset();
        test_load_use();
        test_jr_wait();
        test_freeze();
        test_branch();
        test_exception();
        test_reset_mid_jrwait();
`ifdef HAZ_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
